lsu_bus: RTL and testbench
==========================

Name: lsu_bus

Overview:
- Parametrised successor to the core's combinational load/store unit.
- Turns one core load/store request into one or two word-aligned transactions on a request/grant/response data-memory bus.
- Supports byte-lane steering, sign/zero extension, optional splitting of misaligned accesses, and a response timeout.
- Sits between execute and the data memory; holds `busy` high so fetch stalls through the existing `cpu_wait` path.

Parameters:
- DATA_W, 32, bus/register data width; 32 or 64.
- ADDR_W, 32, byte address width.
- SPLIT_MISALIGNED, 1, 1 = word-crossing access split into two beats; 0 = flagged as error, no bus traffic.
- TIMEOUT, 255, max cycles waiting for mem_rvalid per beat before error; 1..2^16-1.
- NB, DATA_W/8, derived byte-lane count (localparam).

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- req_valid  in  1  core request, sampled only in IDLE
- req_we  in  1  1 = store
- req_size  in  2  0 byte, 1 half, 2 word, 3 dword (DATA_W=64 only)
- req_unsigned  in  1  zero-extend load
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data, right-justified
- busy  out  1  high from request acceptance until rsp_valid cycle inclusive
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DATA_W  extended load data; 0 for stores/errors
- rsp_err  out  1  with rsp_valid: misaligned (SPLIT=0) or timeout
- mem_req  out  1  bus request
- mem_we  out  1  bus write
- mem_addr  out  ADDR_W  NB-aligned address
- mem_be  out  NB  byte enables
- mem_wdata  out  DATA_W  lane-shifted store data
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  response (read data or write ack)
- mem_rdata  in  DATA_W  read data

Behaviour:
- Reset: all outputs 0; FSM IDLE; latched request, beat buffer and timeout counter cleared.
- FSM states: IDLE, REQ0, RSP0, REQ1, RSP1, DONE.
- IDLE, req_valid=1:
  - Latch request. Compute off = addr mod NB, nbytes = 1<<size, cross = off+nbytes > NB.
  - cross && !SPLIT_MISALIGNED → DONE with err=1; no mem_req.
  - Otherwise → REQ0. busy asserts the cycle after acceptance.
- req_size=3 with DATA_W=32: treated as err, same as misaligned.
- REQ0:
  - mem_req=1, mem_addr = addr with low log2(NB) bits cleared.
  - mem_be = ((1<<nbytes)-1)<<off, truncated to NB.
  - mem_wdata = wdata<<(8*off).
  - All bus outputs held stable until mem_gnt; on mem_gnt → RSP0.
- RSP0:
  - Wait mem_rvalid. Capture low-beat lanes; timeout counter cleared on entry, increments each cycle.
  - Counter == TIMEOUT without rvalid → DONE with err=1.
  - rvalid && cross → REQ1; rvalid && !cross → DONE.
- REQ1:
  - mem_addr = aligned address + NB.
  - mem_be = remaining low lanes: (1<<(off+nbytes-NB))-1.
  - mem_wdata = wdata>>(8*(NB-off)).
  - On mem_gnt → RSP1.
- RSP1: same as RSP0; on rvalid or timeout → DONE.
- DONE:
  - rsp_valid=1 for exactly one cycle; busy still 1; → IDLE.
  - Load data = {beat1,beat0}>>(8*off), masked to nbytes, then sign- or zero-extended to DATA_W.
- Bus rules:
  - mem_gnt and mem_rvalid in the same cycle as mem_req: gnt honoured, rvalid ignored unless already in an RSP state.
  - Bus never sees a second request before the prior response.
- Timeout:
  - Each beat has an independent TIMEOUT budget.
  - After a timed-out beat the block returns to IDLE. A late mem_rvalid arriving in IDLE is ignored.
  - After an error no further beats are issued; stores may be partially written (documented, not rolled back).
- Throughput: back-to-back requests accepted in the cycle after DONE (IDLE sampling).
- Minimum aligned-access latency: acceptance → rsp_valid = 3 cycles with gnt/rvalid each in their first possible cycle.
- Reset mid-transaction: immediate return to IDLE, mem_req drops asynchronously, no rsp_valid.

Decomposition:
- Shared package lsu_pkg:
  - size encodings SZ_B/SZ_H/SZ_W/SZ_D
  - FSM state enum
  - function byte_mask(size, off, NB)
- One sub-module, lsu_align: purely combinational lane steering (be, shifted wdata, load extraction/extension), instantiated once in the top.

Test Plan:
- Aligned word load, addr 0x100, mem_rdata 0xDEADBEEF, gnt/rvalid immediate → mem_be 4'b1111, rsp_rdata 0xDEADBEEF, rsp_valid 3 cycles after accept.
- Signed byte load, addr 0x103, rdata 0x80112233 → mem_be 4'b1000, rsp_rdata 0xFFFFFF80; same with req_unsigned=1 → 0x00000080.
- Half store, addr 0x102, wdata 0x0000ABCD → mem_be 4'b1100, mem_wdata 0xABCD0000, mem_we 1, rsp_err 0.
- Misaligned word load, addr 0x0FE, SPLIT=1, beats 0x1122xxxx @0x0FC then 0xxxxx3344 @0x100 → two requests, be 4'b1100 then 4'b0011, rsp_rdata 0x33441122. With SPLIT=0 → no mem_req, rsp_err 1.
- mem_gnt withheld 5 cycles → mem_req/addr/be stable all 5 cycles. mem_rvalid never arrives, TIMEOUT=8 → rsp_valid+rsp_err 8 cycles after gnt, block accepts next request.
- rstn low while in RSP1 → all outputs 0 immediately, no rsp_valid. Next request after release completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings and lane-mask helper for the load/store bus unit.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam int TMO_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    REQ0,
    RSP0,
    REQ1,
    RSP1,
    DONE
  } lsu_state_e;

  // Lane mask spanning two consecutive beats: bits [nb-1:0] first beat, [2nb-1:nb] second.
  function automatic logic [15:0] byte_mask(input logic [1:0] size, input logic [2:0] off,
                                            input int unsigned nb);
    logic [15:0] m;
    m = ((16'd1 << (5'd1 << size)) - 16'd1) << off;
    return m & ((16'd1 << (2 * nb)) - 16'd1);
  endfunction

endpackage

// File: rtl/lsu_bus_if.sv
// Request/grant/response data-memory bus between the LSU (master) and memory (slave).
interface lsu_bus_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  localparam int NB = DATA_W / 8;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [NB-1:0]     mem_be;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport master(
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave(
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane steering: byte enables, shifted store data, load extraction and extension.
module lsu_align
  import lsu_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int NB     = DATA_W / 8,
  localparam int OFF_W  = $clog2(NB),
  localparam int IDX_W  = $clog2(DATA_W)
) (
  input  logic              beat_i,
  input  logic [1:0]        size_i,
  input  logic [OFF_W-1:0]  off_i,
  input  logic              unsigned_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] beat0_i,
  input  logic [DATA_W-1:0] beat1_i,
  output logic [NB-1:0]     be_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [DATA_W-1:0] ldata_o
);

  logic [2*NB-1:0]     mask;
  logic [2*DATA_W-1:0] wide_st;
  logic [DATA_W-1:0]   ld_raw;
  logic [6:0]          nbits;
  logic [IDX_W-1:0]    msb;
  logic                sign;

  assign mask    = (2*NB)'(byte_mask(size_i, 3'(off_i), NB));
  assign be_o    = beat_i ? mask[2*NB-1:NB] : mask[NB-1:0];

  // The upper half of the shifted word is exactly what spills into the second beat.
  assign wide_st = {{DATA_W{1'b0}}, wdata_i} << {off_i, 3'b000};
  assign wdata_o = beat_i ? wide_st[2*DATA_W-1:DATA_W] : wide_st[DATA_W-1:0];

  assign ld_raw  = DATA_W'({beat1_i, beat0_i} >> {off_i, 3'b000});

  always_comb begin
    nbits = 7'd8 << size_i;
    if (nbits > 7'(DATA_W)) nbits = 7'(DATA_W);
    msb     = IDX_W'(nbits - 7'd1);
    sign    = ~unsigned_i & ld_raw[msb];
    ldata_o = '0;
    for (int i = 0; i < DATA_W; i++) begin
      ldata_o[i] = (i < int'(nbits)) ? ld_raw[i] : sign;
    end
  end

endmodule

// File: rtl/lsu_bus.sv
// Load/store unit: one core request becomes one or two aligned bus beats, with per-beat timeout.
module lsu_bus
  import lsu_pkg::*;
#(
  parameter  int DATA_W           = 32,
  parameter  int ADDR_W           = 32,
  parameter  int SPLIT_MISALIGNED = 1,
  parameter  int TIMEOUT          = 255,
  localparam int NB               = DATA_W / 8,
  localparam int OFF_W            = $clog2(NB)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              busy,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  lsu_bus_if.master         bus
);

  lsu_state_e        state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] beat0_q, beat0_d;
  logic [DATA_W-1:0] beat1_q, beat1_d;
  logic              cross_q, cross_d;
  logic              err_q, err_d;
  logic [TMO_W-1:0]  cnt_q, cnt_d;

  logic [4:0]        req_span;
  logic              req_cross, req_bad, tmo;
  logic              issuing, second;
  logic [ADDR_W-1:0] aligned;
  logic [NB-1:0]     be;
  logic [DATA_W-1:0] wdata_sh, ld_data;

  assign req_span  = 5'(req_addr[OFF_W-1:0]) + (5'd1 << req_size);
  assign req_cross = req_span > 5'(NB);
  assign req_bad   = (req_cross && SPLIT_MISALIGNED == 0) || (req_size == SZ_D && DATA_W == 32);
  assign tmo       = cnt_q == TMO_W'(TIMEOUT - 1);

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    beat0_d = beat0_q;
    beat1_d = beat1_q;
    cross_d = cross_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (req_valid) begin
        we_d    = req_we;
        size_d  = req_size;
        uns_d   = req_unsigned;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        cross_d = req_cross;
        err_d   = req_bad;
        beat0_d = '0;
        beat1_d = '0;
        cnt_d   = '0;
        state_d = req_bad ? DONE : REQ0;
      end
      REQ0: if (bus.mem_gnt) begin
        cnt_d   = '0;
        state_d = RSP0;
      end
      RSP0: begin
        if (bus.mem_rvalid) begin
          beat0_d = bus.mem_rdata;
          state_d = cross_q ? REQ1 : DONE;
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      REQ1: if (bus.mem_gnt) begin
        cnt_d   = '0;
        state_d = RSP1;
      end
      RSP1: begin
        if (bus.mem_rvalid) begin
          beat1_d = bus.mem_rdata;
          state_d = DONE;
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      beat0_q <= '0;
      beat1_q <= '0;
      cross_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      beat0_q <= beat0_d;
      beat1_q <= beat1_d;
      cross_q <= cross_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  lsu_align #(.DATA_W(DATA_W)) u_align (
    .beat_i     (second),
    .size_i     (size_q),
    .off_i      (addr_q[OFF_W-1:0]),
    .unsigned_i (uns_q),
    .wdata_i    (wdata_q),
    .beat0_i    (beat0_q),
    .beat1_i    (beat1_q),
    .be_o       (be),
    .wdata_o    (wdata_sh),
    .ldata_o    (ld_data)
  );

  // All outputs decode the registered state, so reset clears them without waiting for a clock.
  assign issuing       = (state_q == REQ0) || (state_q == REQ1);
  assign second        = (state_q == REQ1);
  assign aligned       = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  assign bus.mem_req   = issuing;
  assign bus.mem_we    = issuing & we_q;
  assign bus.mem_addr  = issuing ? (second ? aligned + ADDR_W'(NB) : aligned) : '0;
  assign bus.mem_be    = issuing ? be : '0;
  assign bus.mem_wdata = issuing ? wdata_sh : '0;

  assign busy          = (state_q != IDLE);
  assign rsp_valid     = (state_q == DONE);
  assign rsp_err       = rsp_valid & err_q;
  assign rsp_rdata     = (rsp_valid && !err_q && !we_q) ? ld_data : '0;

endmodule

// File: tb/tb_lsu_bus.sv
// Scoreboard bench for lsu_bus: split and non-split instances driven by a scripted memory.
`timescale 1ns/1ps
module tb_lsu_bus;
  import lsu_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          req_valid, req_valid_ns, req_we, req_unsigned;
  logic [1:0]    req_size;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          busy, rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          busy_ns, rsp_valid_ns, rsp_err_ns;
  logic [DW-1:0] rsp_rdata_ns;

  int n_vec = 0;
  int n_err = 0;
  exp_t exp_q[$];

  lsu_bus_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  lsu_bus_if #(.DATA_W(DW), .ADDR_W(AW)) bus_ns ();

  lsu_bus #(.DATA_W(DW), .ADDR_W(AW), .SPLIT_MISALIGNED(1), .TIMEOUT(8)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .bus(bus)
  );

  lsu_bus #(.DATA_W(DW), .ADDR_W(AW), .SPLIT_MISALIGNED(0), .TIMEOUT(8)) dut_ns (
    .clk(clk), .rstn(rstn), .req_valid(req_valid_ns), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy_ns), .rsp_valid(rsp_valid_ns), .rsp_rdata(rsp_rdata_ns), .rsp_err(rsp_err_ns),
    .bus(bus_ns)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit ns, input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input logic exp_er);
    exp_t e;
    e.rdata = exp_rd;
    e.err   = exp_er;
    exp_q.push_back(e);
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    if (ns) req_valid_ns = 1'b1;
    else    req_valid    = 1'b1;
    tick();
    req_valid = 1'b0; req_valid_ns = 1'b0;
  endtask

  // Plays memory for one beat: waits for mem_req, holds gnt off gdly cycles, optionally responds.
  task automatic serve(input int gdly, input bit rv, input logic [31:0] rdata,
                       output bit seen, output logic [31:0] a, output logic [3:0] be,
                       output logic [31:0] wd, output logic we, output bit stable);
    seen = 1'b0;
    stable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (bus.mem_req === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    a = bus.mem_addr; be = bus.mem_be; wd = bus.mem_wdata; we = bus.mem_we;
    if (!seen) return;
    for (int i = 0; i < gdly; i++) begin
      tick();
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== a || bus.mem_be !== be ||
          bus.mem_wdata !== wd || bus.mem_we !== we) stable = 1'b0;
    end
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    if (rv) begin
      bus.mem_rdata  = rdata;
      bus.mem_rvalid = 1'b1;
      tick();
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = '0;
    end
  endtask

  task automatic wait_rsp(input bit ns, input int maxc, output bit got, output int n,
                          output logic [31:0] rd, output logic er);
    got = 1'b0;
    n = 0;
    for (int i = 0; i <= maxc; i++) begin
      if ((ns ? rsp_valid_ns : rsp_valid) === 1'b1) begin
        got = 1'b1;
        break;
      end
      tick();
      n++;
    end
    rd = ns ? rsp_rdata_ns : rsp_rdata;
    er = ns ? rsp_err_ns : rsp_err;
  endtask

  task automatic test_reset();
    tick(); tick();
    n_vec++;
    if ({busy, rsp_valid, rsp_err, bus.mem_req, bus.mem_we, busy_ns, bus_ns.mem_req} !== 7'b0 ||
        rsp_rdata !== '0 || bus.mem_addr !== '0 || bus.mem_be !== '0 || bus.mem_wdata !== '0) begin
      n_err++;
      $display("FAIL reset_outputs busy=%b rsp_valid=%b mem_req=%b addr=%h be=%b required all zero",
               busy, rsp_valid, bus.mem_req, bus.mem_addr, bus.mem_be);
    end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_word_load();
    bit seen, st, got; logic [31:0] a, wd, rd; logic [3:0] be; logic we, er; int n, t0; exp_t e;
    t0 = cyc;
    issue(0, 1'b0, SZ_W, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0);
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL busy_after_accept got=%b required=1", busy);
    end
    serve(0, 1, 32'hDEADBEEF, seen, a, be, wd, we, st);
    n_vec++;
    if (!seen || a !== 32'h100 || be !== 4'b1111 || we !== 1'b0) begin
      n_err++; $display("FAIL word_load_bus seen=%b addr=%h be=%b we=%b required addr=00000100 be=1111 we=0", seen, a, be, we);
    end
    wait_rsp(0, 20, got, n, rd, er);
    e = exp_q.pop_front();
    n_vec++;
    if (!got || rd !== e.rdata || er !== e.err) begin
      n_err++; $display("FAIL word_load_rsp got=%b rdata=%h err=%b required rdata=%h err=%b", got, rd, er, e.rdata, e.err);
    end
    n_vec++;
    if (cyc - t0 != 3) begin
      n_err++; $display("FAIL word_load_latency cycles=%0d required=3", cyc - t0);
    end
    tick();
    n_vec++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL rsp_pulse_width rsp_valid=%b busy=%b required 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_byte_load();
    bit seen, st, got; logic [31:0] a, wd, rd; logic [3:0] be; logic we, er; int n; exp_t e;
    for (int u = 0; u < 2; u++) begin
      issue(0, 1'b0, SZ_B, u[0], 32'h103, 32'h0, (u == 0) ? 32'hFFFFFF80 : 32'h00000080, 1'b0);
      serve(0, 1, 32'h80112233, seen, a, be, wd, we, st);
      n_vec++;
      if (!seen || a !== 32'h100 || be !== 4'b1000) begin
        n_err++; $display("FAIL byte_load_be uns=%0d addr=%h be=%b required addr=00000100 be=1000", u, a, be);
      end
      wait_rsp(0, 20, got, n, rd, er);
      e = exp_q.pop_front();
      n_vec++;
      if (!got || rd !== e.rdata || er !== e.err) begin
        n_err++; $display("FAIL byte_load_rsp uns=%0d rdata=%h err=%b required rdata=%h err=%b", u, rd, er, e.rdata, e.err);
      end
      tick();
    end
  endtask

  task automatic test_half_store();
    bit seen, st, got; logic [31:0] a, wd, rd; logic [3:0] be; logic we, er; int n; exp_t e;
    issue(0, 1'b1, SZ_H, 1'b0, 32'h102, 32'h0000ABCD, 32'h0, 1'b0);
    serve(0, 1, 32'h0, seen, a, be, wd, we, st);
    n_vec++;
    if (!seen || a !== 32'h100 || be !== 4'b1100 || wd !== 32'hABCD0000 || we !== 1'b1) begin
      n_err++; $display("FAIL half_store_bus addr=%h be=%b wdata=%h we=%b required 00000100 1100 abcd0000 1", a, be, wd, we);
    end
    wait_rsp(0, 20, got, n, rd, er);
    e = exp_q.pop_front();
    n_vec++;
    if (!got || rd !== e.rdata || er !== e.err) begin
      n_err++; $display("FAIL half_store_rsp rdata=%h err=%b required rdata=%h err=%b", rd, er, e.rdata, e.err);
    end
    tick();
  endtask

  task automatic test_misaligned();
    bit seen, st, got; logic [31:0] a, wd, rd; logic [3:0] be; logic we, er; int n; exp_t e;
    issue(0, 1'b0, SZ_W, 1'b0, 32'h0FE, 32'h0, 32'h33441122, 1'b0);
    serve(0, 1, 32'h11225566, seen, a, be, wd, we, st);
    n_vec++;
    if (!seen || a !== 32'h0FC || be !== 4'b1100) begin
      n_err++; $display("FAIL split_load_beat0 addr=%h be=%b required 000000fc 1100", a, be);
    end
    serve(0, 1, 32'h77883344, seen, a, be, wd, we, st);
    n_vec++;
    if (!seen || a !== 32'h100 || be !== 4'b0011) begin
      n_err++; $display("FAIL split_load_beat1 seen=%b addr=%h be=%b required 00000100 0011", seen, a, be);
    end
    wait_rsp(0, 20, got, n, rd, er);
    e = exp_q.pop_front();
    n_vec++;
    if (!got || rd !== e.rdata || er !== e.err) begin
      n_err++; $display("FAIL split_load_rsp rdata=%h err=%b required rdata=%h err=%b", rd, er, e.rdata, e.err);
    end
    tick();
    issue(0, 1'b1, SZ_W, 1'b0, 32'h0FE, 32'hA1B2C3D4, 32'h0, 1'b0);
    serve(0, 1, 32'h0, seen, a, be, wd, we, st);
    n_vec++;
    if (!seen || a !== 32'h0FC || be !== 4'b1100 || wd !== 32'hC3D40000 || we !== 1'b1) begin
      n_err++; $display("FAIL split_store_beat0 addr=%h be=%b wdata=%h required 000000fc 1100 c3d40000", a, be, wd);
    end
    serve(0, 1, 32'h0, seen, a, be, wd, we, st);
    n_vec++;
    if (!seen || a !== 32'h100 || be !== 4'b0011 || wd !== 32'h0000A1B2) begin
      n_err++; $display("FAIL split_store_beat1 addr=%h be=%b wdata=%h required 00000100 0011 0000a1b2", a, be, wd);
    end
    wait_rsp(0, 20, got, n, rd, er);
    e = exp_q.pop_front();
    n_vec++;
    if (!got || rd !== e.rdata || er !== e.err) begin
      n_err++; $display("FAIL split_store_rsp rdata=%h err=%b required rdata=%h err=%b", rd, er, e.rdata, e.err);
    end
    tick();
  endtask

  task automatic test_error_paths();
    bit got; logic [31:0] rd; logic er; int n; exp_t e;
    issue(1, 1'b0, SZ_W, 1'b0, 32'h0FE, 32'h0, 32'h0, 1'b1);
    wait_rsp(1, 5, got, n, rd, er);
    e = exp_q.pop_front();
    n_vec++;
    if (!got || n != 0 || rd !== e.rdata || er !== e.err || bus_ns.mem_req !== 1'b0) begin
      n_err++; $display("FAIL nosplit_err got=%b wait=%0d rdata=%h err=%b mem_req=%b required 1 0 %h %b 0", got, n, rd, er, bus_ns.mem_req, e.rdata, e.err);
    end
    tick();
    n_vec++;
    if (busy_ns !== 1'b0 || bus_ns.mem_req !== 1'b0) begin
      n_err++; $display("FAIL nosplit_idle busy=%b mem_req=%b required 0 0", busy_ns, bus_ns.mem_req);
    end
    issue(0, 1'b0, SZ_D, 1'b0, 32'h200, 32'h0, 32'h0, 1'b1);
    wait_rsp(0, 5, got, n, rd, er);
    e = exp_q.pop_front();
    n_vec++;
    if (!got || n != 0 || er !== e.err || rd !== e.rdata || bus.mem_req !== 1'b0) begin
      n_err++; $display("FAIL dword_on_32_err got=%b wait=%0d err=%b mem_req=%b required 1 0 1 0", got, n, er, bus.mem_req);
    end
    tick();
  endtask

  task automatic test_timeout();
    bit seen, st, got; logic [31:0] a, wd, rd; logic [3:0] be; logic we, er; int n; exp_t e;
    issue(0, 1'b0, SZ_W, 1'b0, 32'h104, 32'h0, 32'h0, 1'b1);
    serve(5, 0, 32'h0, seen, a, be, wd, we, st);
    n_vec++;
    if (!seen || !st || a !== 32'h104 || be !== 4'b1111) begin
      n_err++; $display("FAIL gnt_stall_stable seen=%b stable=%b addr=%h be=%b required 1 1 00000104 1111", seen, st, a, be);
    end
    wait_rsp(0, 30, got, n, rd, er);
    e = exp_q.pop_front();
    n_vec++;
    if (!got || n != 8 || rd !== e.rdata || er !== e.err) begin
      n_err++; $display("FAIL timeout_rsp got=%b cycles=%0d rdata=%h err=%b required 1 8 %h %b", got, n, rd, er, e.rdata, e.err);
    end
    tick();
    issue(0, 1'b0, SZ_W, 1'b0, 32'h108, 32'h0, 32'h12345678, 1'b0);
    serve(0, 1, 32'h12345678, seen, a, be, wd, we, st);
    wait_rsp(0, 20, got, n, rd, er);
    e = exp_q.pop_front();
    n_vec++;
    if (!got || a !== 32'h108 || rd !== e.rdata || er !== e.err) begin
      n_err++; $display("FAIL after_timeout_rsp addr=%h rdata=%h err=%b required 00000108 %h %b", a, rd, er, e.rdata, e.err);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bit seen, st, got, spurious; logic [31:0] a, wd, rd; logic [3:0] be; logic we, er; int n; exp_t e;
    issue(0, 1'b0, SZ_W, 1'b0, 32'h0FE, 32'h0, 32'h0, 1'b0);
    serve(0, 1, 32'hAAAA5555, seen, a, be, wd, we, st);
    serve(0, 0, 32'h0, seen, a, be, wd, we, st);
    e = exp_q.pop_front();
    #2;
    rstn = 1'b0;
    #1;
    n_vec++;
    if ({busy, rsp_valid, rsp_err, bus.mem_req, bus.mem_we} !== 5'b0 || rsp_rdata !== '0 ||
        bus.mem_addr !== '0 || bus.mem_be !== '0) begin
      n_err++; $display("FAIL async_reset_outputs busy=%b rsp_valid=%b mem_req=%b addr=%h required all zero", busy, rsp_valid, bus.mem_req, bus.mem_addr);
    end
    spurious = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (rsp_valid !== 1'b0 || busy !== 1'b0) spurious = 1'b1;
    end
    rstn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (rsp_valid !== 1'b0 || busy !== 1'b0) spurious = 1'b1;
    end
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    n_vec++;
    if (spurious) begin
      n_err++; $display("FAIL reset_no_rsp spurious rsp_valid/busy=1 required 0");
    end
    issue(0, 1'b0, SZ_H, 1'b1, 32'h10E, 32'h0, 32'h0000CAFE, 1'b0);
    serve(0, 1, 32'hCAFEF00D, seen, a, be, wd, we, st);
    wait_rsp(0, 20, got, n, rd, er);
    e = exp_q.pop_front();
    n_vec++;
    if (!got || a !== 32'h10C || be !== 4'b1100 || rd !== e.rdata || er !== e.err) begin
      n_err++; $display("FAIL after_reset_rsp addr=%h be=%b rdata=%h err=%b required 0000010c 1100 %h %b", a, be, rd, er, e.rdata, e.err);
    end
    tick();
  endtask

  initial begin
    req_valid = 1'b0; req_valid_ns = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    bus_ns.mem_gnt = 1'b0; bus_ns.mem_rvalid = 1'b0; bus_ns.mem_rdata = '0;
    test_reset();
    test_word_load();
    test_byte_load();
    test_half_store();
    test_misaligned();
    test_error_paths();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
